// File: rtl/riscv_loader_pkg.sv
// rtl/riscv_loader_pkg.sv - shared types and constants for the RISC-V program loader
//
// Holds the loader FSM state type and the RV32I canonical NOP used to pad
// an odd final instruction into a full 64-bit memory word.
package riscv_loader_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_LO = 3'd1,
      LOAD_HI = 3'd2,
      WRITE   = 3'd3,
      HOLD    = 3'd4,
      DONE    = 3'd5
   } loader_state_t;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/riscv_prog_loader.sv
// rtl/riscv_prog_loader.sv - streams 32-bit instructions into 64-bit memory words, then releases core reset
//
// Optional feature macro: RISCV_PROG_LOADER_CHECKSUM_EN adds checksum[31:0].
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 begin a load session (ignored while busy)
//   in_valid/in_ready     32-bit instruction stream handshake, in_data, in_last
//   mem_req/mem_gnt       one 64-bit write per grant at mem_idx with mem_wdata
//   core_resetn           active-low core reset, released only in DONE
//   busy, done, error     session status; error is sticky for words beyond MAX_WORDS
//   word_count            accepted words this session, saturating
//   checksum              XOR of stored words (only with the checksum macro)
module riscv_prog_loader
   import riscv_loader_pkg::*;
#(
   parameter int          XLEN        = 64,
   parameter logic [63:0] BASE_ADDR   = 64'h0000_1000,
   parameter int          MEM_IDX_W   = 16,
   parameter int          MAX_WORDS   = 1024,
   parameter int          HOLD_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_data,
   input  logic                 in_last,
   output logic                 mem_req,
   input  logic                 mem_gnt,
   output logic [MEM_IDX_W-1:0] mem_idx,
   output logic [XLEN-1:0]      mem_wdata,
   output logic                 core_resetn,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [15:0]          word_count
`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
   ,
   output logic [31:0]          checksum
`endif
);

   // Memory is word-indexed in 8-byte units; the index wraps naturally.
   localparam logic [MEM_IDX_W-1:0] BASE_IDX  = MEM_IDX_W'(BASE_ADDR >> 3);
   localparam logic [16:0]          MAX_W     = 17'(MAX_WORDS);
   localparam logic [31:0]          HOLD_LAST = 32'(HOLD_CYCLES - 1);

   loader_state_t state;
   loader_state_t state_nx;

   logic        accept;
   logic        drop;
   logic        launch;
   logic        last_pair;
   logic        hold_end;
   logic [31:0] hold_cnt;

   assign in_ready    = (state == LOAD_LO) || (state == LOAD_HI);
   assign mem_req     = (state == WRITE);
   assign busy        = (state != IDLE) && (state != DONE);
   assign done        = (state == DONE);
   assign core_resetn = (state == DONE);

   assign accept   = in_valid && in_ready;
   // Once capacity is reached every further word is swallowed, not just the first.
   assign drop     = accept && ({1'b0, word_count} >= MAX_W);
   assign launch   = start && !busy;
   assign hold_end = (hold_cnt == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) state_nx = LOAD_LO;
         end
         LOAD_LO: begin
            if (accept) begin
               if (drop) begin
                  // Nothing buffered, so a dropped last word ends without a write.
                  if (in_last) state_nx = HOLD;
               end else if (in_last) begin
                  state_nx = WRITE;
               end else begin
                  state_nx = LOAD_HI;
               end
            end
         end
         LOAD_HI: begin
            if (accept) begin
               // A dropped last word still flushes the buffered low half, NOP padded.
               if (in_last || !drop) state_nx = WRITE;
            end
         end
         WRITE: begin
            if (mem_gnt) state_nx = last_pair ? HOLD : LOAD_LO;
         end
         HOLD: begin
            if (hold_end) state_nx = DONE;
         end
         DONE: begin
            if (start) state_nx = LOAD_LO;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_idx    <= BASE_IDX;
         mem_wdata  <= '0;
         word_count <= '0;
         error      <= 1'b0;
         last_pair  <= 1'b0;
         hold_cnt   <= '0;
      end else begin
         hold_cnt <= (state == HOLD) ? hold_cnt + 32'd1 : 32'd0;

         if (launch) begin
            word_count <= '0;
            error      <= 1'b0;
            mem_idx    <= BASE_IDX;
            last_pair  <= 1'b0;
         end

         if (accept) begin
            if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
            if (in_last) last_pair <= 1'b1;
            if (drop) begin
               error <= 1'b1;
               if ((state == LOAD_HI) && in_last) mem_wdata[63:32] <= NOP_INSN;
            end else if (state == LOAD_LO) begin
               mem_wdata[31:0] <= in_data;
               if (in_last) mem_wdata[63:32] <= NOP_INSN;
            end else begin
               mem_wdata[63:32] <= in_data;
            end
         end

         if ((state == WRITE) && mem_gnt) mem_idx <= mem_idx + MEM_IDX_W'(1);
      end
   end

`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         checksum <= '0;
      end else if (launch) begin
         checksum <= '0;
      end else if (accept && !drop) begin
         checksum <= checksum ^ in_data;
      end
   end
`endif

endmodule

// File: tb/tb_riscv_prog_loader.sv
// tb/tb_riscv_prog_loader.sv - scoreboard bench for riscv_prog_loader (default and MAX_WORDS=4 instances)
//
// Optional feature macro: RISCV_PROG_LOADER_CHECKSUM_EN enables the checksum case.
module tb_riscv_prog_loader;

   typedef struct packed {
      logic        inst;
      logic [15:0] idx;
      logic [63:0] data;
   } wr_t;

   logic        clk;
   logic        reset;
   logic        start       [2];
   logic        in_valid    [2];
   logic        in_ready    [2];
   logic [31:0] in_data     [2];
   logic        in_last     [2];
   logic        mem_req     [2];
   logic        mem_gnt     [2];
   logic [15:0] mem_idx     [2];
   logic [63:0] mem_wdata   [2];
   logic        core_resetn [2];
   logic        busy        [2];
   logic        done        [2];
   logic        error       [2];
   logic [15:0] word_count  [2];
`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
   logic [31:0] checksum    [2];
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          wr_cnt  [2];
   int          gnt_cyc [2];
   int          done_cyc;
   bit          gnt_en;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [31:0] words[$];

   riscv_prog_loader dut0 (
      .clk(clk), .reset(reset), .start(start[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
      .mem_req(mem_req[0]), .mem_gnt(mem_gnt[0]), .mem_idx(mem_idx[0]), .mem_wdata(mem_wdata[0]),
      .core_resetn(core_resetn[0]), .busy(busy[0]), .done(done[0]), .error(error[0]),
      .word_count(word_count[0])
`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
      , .checksum(checksum[0])
`endif
   );

   riscv_prog_loader #(.MAX_WORDS(4)) dut1 (
      .clk(clk), .reset(reset), .start(start[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
      .mem_req(mem_req[1]), .mem_gnt(mem_gnt[1]), .mem_idx(mem_idx[1]), .mem_wdata(mem_wdata[1]),
      .core_resetn(core_resetn[1]), .busy(busy[1]), .done(done[1]), .error(error[1]),
      .word_count(word_count[1])
`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
      , .checksum(checksum[1])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int i, input logic [15:0] idx, input logic [63:0] data);
      wr_t e;
      e.inst = i[0];
      e.idx  = idx;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Memory-side monitor: every granted write must match the head of the scoreboard.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mem_req[i] && mem_gnt[i]) begin
            wr_cnt[i]++;
            gnt_cyc[i] = cyc + 1;
            if (exp_q.size() == 0) begin
               check("unexpected_write", 64'(i), 64'hFF);
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_inst", 64'(i), 64'(mon_e.inst));
               check("wr_idx", 64'(mem_idx[i]), 64'(mon_e.idx));
               check("wr_data", mem_wdata[i], mon_e.data);
            end
         end
      end
   end

   // Grant responder: random back-pressure while enabled.
   initial begin
      mem_gnt[0] = 1'b0;
      mem_gnt[1] = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) mem_gnt[i] = gnt_en && ($urandom_range(0, 2) != 0);
      end
   end

   task automatic send_word(input int i, input logic [31:0] w, input logic last);
      bit ok = 0;
      bit rdy;
      in_data[i]  = w;
      in_last[i]  = last;
      in_valid[i] = 1'b1;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         rdy = in_ready[i];
         tick();
         if (rdy) begin
            ok = 1;
            break;
         end
      end
      in_valid[i] = 1'b0;
      in_last[i]  = 1'b0;
      if (!ok) check("send_timeout", 0, 1);
      if ($urandom_range(0, 3) == 0) tick();
   endtask

   task automatic pulse_start(input int i);
      start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
   endtask

   task automatic wait_done(input int i);
      bit ok = 0;
      for (int t = 0; t < 500; t++) begin
         @(negedge clk);
         if (done[i]) begin
            ok = 1;
            done_cyc = cyc;
            break;
         end
      end
      check("done_reached", 64'(ok), 1);
      tick();
   endtask

   // Streams the global word list into instance i and checks end-of-session status.
   task automatic run_session(input int i, input int max_w, input string name);
      int          cnt = 0;
      int          np = 0;
      bit          have_lo = 0;
      bit          err = 0;
      logic [31:0] lo = '0;
      logic [31:0] ck = '0;
      int          wr0;
      for (int k = 0; k < words.size(); k++) begin
         if (cnt >= max_w) begin
            err = 1;
         end else begin
            ck ^= words[k];
            if (have_lo) begin
               push_exp(i, 16'h0200 + 16'(np), {words[k], lo});
               np++;
               have_lo = 0;
            end else begin
               lo = words[k];
               have_lo = 1;
            end
         end
         if (cnt < 65535) cnt++;
      end
      if (have_lo) begin
         push_exp(i, 16'h0200 + 16'(np), {32'h0000_0013, lo});
         np++;
      end
      wr0 = wr_cnt[i];
      pulse_start(i);
      check({name, "_busy_corerst"}, {62'd0, busy[i], core_resetn[i]}, 64'b10);
      for (int k = 0; k < words.size(); k++) send_word(i, words[k], k == words.size() - 1);
      wait_done(i);
      check({name, "_word_count"}, 64'(word_count[i]), 64'(cnt));
      check({name, "_error"}, 64'(error[i]), 64'(err));
      check({name, "_writes"}, 64'(wr_cnt[i] - wr0), 64'(np));
      check({name, "_end_status"}, {61'd0, core_resetn[i], busy[i], done[i]}, 64'b101);
      if (!err) check({name, "_hold_latency"}, 64'(done_cyc - gnt_cyc[i]), 64'd4);
`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
      check({name, "_checksum"}, 64'(checksum[i]), 64'(ck));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int wr0;
      bit ok;
      gnt_en = 1'b0;
      reset  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0; in_last[i] = 1'b0;
         wr_cnt[i] = 0; gnt_cyc[i] = 0;
      end
      repeat (3) tick();
      reset = 1'b0;

      check("rst_in_ready", 64'(in_ready[0]), 0);
      check("rst_mem_req", 64'(mem_req[0]), 0);
      check("rst_core_resetn", 64'(core_resetn[0]), 0);
      check("rst_busy_done_err", {61'd0, busy[0], done[0], error[0]}, 0);
      check("rst_word_count", 64'(word_count[0]), 0);
      check("rst_mem_idx", 64'(mem_idx[0]), 64'h200);
      check("rst_mem_wdata", mem_wdata[0], 0);
      gnt_en = 1'b1;

      // Odd-length program with NOP padding on the last pair.
      words = '{32'h00a00093, 32'h01400113, 32'h002081b3, 32'h40208233, 32'h0020f2b3,
                32'h0020e333, 32'h0020c3b3, 32'h00209433, 32'h0020d4b3, 32'h00000013,
                32'h00100073};
      run_session(0, 1024, "s11");

      // Restart from DONE: count and index return to their session start values.
      words = '{32'hAAAA0001, 32'hBBBB0002};
      run_session(0, 1024, "s2");

      // Memory stall: write must hold steady and stream must back off.
      push_exp(0, 16'h0200, 64'h2222_0002_1111_0001);
      push_exp(0, 16'h0201, 64'h4444_0004_3333_0003);
      gnt_en = 1'b0;
      pulse_start(0);
      send_word(0, 32'h1111_0001, 1'b0);
      send_word(0, 32'h2222_0002, 1'b0);
      ok = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (mem_req[0]) begin
            ok = 1;
            break;
         end
      end
      check("stall_req_seen", 64'(ok), 1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("stall_req_ready", {62'd0, mem_req[0], in_ready[0]}, 64'b10);
         check("stall_idx", 64'(mem_idx[0]), 64'h200);
         check("stall_wdata", mem_wdata[0], 64'h2222_0002_1111_0001);
         @(posedge clk);
         #1;
         start[0] = (k == 3);
      end
      start[0] = 1'b0;
      gnt_en = 1'b1;
      send_word(0, 32'h3333_0003, 1'b0);
      send_word(0, 32'h4444_0004, 1'b1);
      wait_done(0);
      check("stall_word_count", 64'(word_count[0]), 4);

      // Capacity overflow on the MAX_WORDS=4 instance.
      words = '{32'h5000_0001, 32'h5000_0002, 32'h5000_0003, 32'h5000_0004,
                32'h5000_0005, 32'h5000_0006};
      run_session(1, 4, "cap");

      // Reset mid-session with a half-filled pair pending.
      push_exp(0, 16'h0200, 64'h7000_0002_7000_0001);
      pulse_start(0);
      send_word(0, 32'h7000_0001, 1'b0);
      send_word(0, 32'h7000_0002, 1'b0);
      send_word(0, 32'h7000_0003, 1'b0);
      wr0 = wr_cnt[0];
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mrst_in_ready_req", {62'd0, in_ready[0], mem_req[0]}, 0);
      check("mrst_core_busy_done", {61'd0, core_resetn[0], busy[0], done[0]}, 0);
      check("mrst_word_count", 64'(word_count[0]), 0);
      check("mrst_mem_idx", 64'(mem_idx[0]), 64'h200);
      repeat (8) tick();
      check("mrst_no_write", 64'(wr_cnt[0] - wr0), 0);

`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
      words = '{32'h0000_00FF, 32'h0000_0F0F};
      run_session(0, 1024, "cks");
      check("cks_value", 64'(checksum[0]), 64'h0000_0FF0);
`endif

      repeat (3) tick();
      check("scoreboard_empty", 64'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/riscv_prog_loader.md
RISCV_PROG_LOADER -- requirements
Module: riscv_prog_loader

Interface
REQ-001 SHALL have parameter XLEN, default 64: core/memory data width; only 64 is supported.
REQ-002 SHALL have parameter BASE_ADDR, default 64'h0000_1000: byte address of the first instruction; must be 8-byte aligned.
REQ-003 SHALL have parameter MEM_IDX_W, default 16: width of the memory word index.
REQ-004 SHALL have parameter MAX_WORDS, default 1024: capacity in 32-bit instructions.
REQ-005 SHALL have parameter HOLD_CYCLES, default 4: core reset hold after the final write.
REQ-006 SHALL have ports: clk, in, 1, sole clock (all logic on its rising edge).
REQ-007 SHALL have ports: reset, in, 1, reset (synchronous, active-high).
REQ-008 SHALL have ports: start, in, 1, begin a load session.
REQ-009 SHALL have ports: in_valid, in, 1; in_ready, out, 1; in_data, in, 32; in_last, in, 1: instruction stream.
REQ-010 SHALL have ports: mem_req, out, 1; mem_gnt, in, 1; mem_idx, out, MEM_IDX_W; mem_wdata, out, 64: memory write.
REQ-011 SHALL have ports: core_resetn, out, 1, active-low reset to the core.
REQ-012 SHALL have ports: busy, out, 1; done, out, 1; error, out, 1; word_count, out, 16.

Function
REQ-013 SHALL implement states IDLE, LOAD_LO, LOAD_HI, WRITE, HOLD, DONE.
REQ-014 Transitions SHALL be: IDLE --start--> LOAD_LO; LOAD_LO accepts word -> LOAD_HI, or -> WRITE if in_last; LOAD_HI accepts word -> WRITE; WRITE --mem_gnt--> LOAD_LO, or -> HOLD if the pair held last; HOLD, after HOLD_CYCLES cycles -> DONE; DONE --start--> LOAD_LO.
REQ-015 in_ready SHALL be 1 only in LOAD_LO and LOAD_HI; a word transfers when in_valid && in_ready.
REQ-016 Packing SHALL be little-endian: the first word of a pair goes to mem_wdata[31:0], the second to [63:32].
REQ-017 Odd counts: when in_last arrives in LOAD_LO, [63:32] SHALL be padded with NOP 32'h0000_0013.
REQ-018 mem_idx SHALL be (BASE_ADDR>>3) + pair number, wrapping modulo 2^MEM_IDX_W.
REQ-019 mem_req SHALL be asserted only in WRITE, with mem_idx/mem_wdata held stable until the cycle in which mem_gnt=1 (one write per grant).
REQ-020 mem_gnt=0 SHALL stall indefinitely with no data loss; mem_gnt outside WRITE SHALL be ignored.
REQ-021 word_count SHALL increment per accepted word and saturate at 16'hFFFF; it is not incremented for padding.
REQ-022 An accepted word with word_count==MAX_WORDS SHALL set error sticky, be dropped (not written), and still complete the handshake; in_last on a dropped word still ends the session.
REQ-023 core_resetn SHALL be 0 from start until HOLD completes, and 1 in DONE; busy = state not in {IDLE, DONE}; done = (state==DONE).
REQ-024 start while busy SHALL be ignored.
REQ-025 A new session from DONE SHALL clear word_count and error and restart mem_idx at base.
REQ-026 Latency SHALL be: a pair is written the cycle after the second word is accepted at the earliest; core_resetn rises exactly HOLD_CYCLES cycles after the final grant.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE, in_ready=0, mem_req=0, core_resetn=0, busy=0, done=0, error=0, word_count=0, mem_idx=BASE_ADDR>>3, and mem_wdata=0.
REQ-028 Reset mid-session SHALL abandon any partial pair with no write issued.

Configuration
REQ-029 With RISCV_PROG_LOADER_CHECKSUM_EN defined, the block SHALL add output checksum[31:0]: XOR of all accepted, non-dropped words (padding excluded), cleared at reset and at start, valid when done=1.
REQ-030 Without RISCV_PROG_LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent.

Structure
REQ-031 Package riscv_loader_pkg SHALL hold the state enum typedef and the NOP constant 32'h0000_0013.
REQ-032 No sub-module is required; the block is a single module.

Verification
REQ-033 Stream 11 words 00a00093, 01400113, ... 00100073 (last) -> 6 writes at idx 0x200..0x205, last mem_wdata = {00000013, 00100073}, word_count=11.
REQ-034 Stream 2 words AAAA0001, BBBB0002 (last) -> one write idx 0x200, wdata = BBBB0002_AAAA0001, core_resetn rises 4 cycles after the grant.
REQ-035 Hold mem_gnt=0 for 10 cycles -> mem_req, mem_idx, and mem_wdata stay stable, in_ready=0, and no word is lost.
REQ-036 MAX_WORDS=4, stream 6 words -> error=1, 2 writes only, done reached.
REQ-037 Assert reset after 3 words -> IDLE, no write for the third word, core_resetn=0.
REQ-038 CHECKSUM_EN, words 0000_00FF, 0000_0F0F (last) -> checksum=0000_0FF0.
